// File: rtl/lin_adder_pkg.sv
// Shared constants and configuration checks for the pipelined linearised adder.
package lin_adder_pkg;

  localparam logic CIN_ADD = 1'b0;
  localparam logic CIN_SUB = 1'b1;

  function automatic bit lin_seg_ok(input int unsigned n, input int unsigned s);
    return (s >= 1) && (s <= n) && ((n % s) == 0);
  endfunction

endpackage

// File: rtl/lin_seg_add.sv
// One SEG-bit combinational slice: sum = a ^ b ^ c with a generate/propagate ripple.
module lin_seg_add #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic [SEG-1:0] carry,
  output logic           cout
);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;
  logic [SEG:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int unsigned j = 0; j < SEG; j++) begin
      w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
    end
  end

  assign carry = w_c[SEG-1:0];
  assign cout  = w_c[SEG];
  assign sum   = w_p ^ carry;

endmodule

// File: rtl/lin_adder_pipe.sv
// Pipelined segmented add/subtract: one SEG-bit slice resolved per stage, with
// valid/ready backpressure and multi-word carry chaining through carry_hold.
module lin_adder_pipe
  import lin_adder_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_chain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_co,
  output logic         out_ovf,
  output logic [N-1:0] out_carry
);

  localparam int unsigned SEG = N / S;

  if (!lin_seg_ok(N, S)) begin : g_bad_cfg
    $error("lin_adder_pipe: N must be a multiple of S with 1 <= S <= N");
  end

  // Payload widths follow N, so the stage struct lives here rather than in the package.
  typedef struct packed {
    logic         valid;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic [N-1:0] carry;
    logic         cout;
  } stage_t;

  stage_t       r_stg [S];
  stage_t       w_nxt [S];
  stage_t       w_in;
  logic [S-1:0] w_load;
  logic         w_mid_empty;
  logic         w_cin;
  logic [N-1:0] w_b_eff;
  logic         r_carry_hold;
  logic         w_unused;

  assign w_cin   = in_chain ? r_carry_hold : (in_sub ? CIN_SUB : CIN_ADD);
  assign w_b_eff = in_sub ? ~in_b : in_b;

  always_comb begin
    w_in       = '0;
    w_in.valid = in_valid & in_ready;
    w_in.sub   = in_sub;
    w_in.a     = in_a;
    w_in.b     = w_b_eff;
  end

  always_comb begin
    w_load      = '0;
    w_load[S-1] = !r_stg[S-1].valid | out_ready;
    for (int unsigned i = 1; i < S; i++) begin
      w_load[S-1-i] = !r_stg[S-1-i].valid | w_load[S-i];
    end
  end

  // A chained beat needs its predecessor's carry already captured in carry_hold.
  always_comb begin
    w_mid_empty = 1'b1;
    for (int unsigned i = 0; i + 1 < S; i++) begin
      if (r_stg[i].valid) w_mid_empty = 1'b0;
    end
  end

  assign in_ready = w_load[0] & (!in_chain | w_mid_empty);

  for (genvar k = 0; k < S; k++) begin : g_stage
    stage_t         w_src;
    stage_t         w_res;
    logic           w_seg_cin;
    logic [SEG-1:0] w_seg_sum;
    logic [SEG-1:0] w_seg_carry;
    logic           w_seg_cout;

    if (k == 0) begin : g_first
      assign w_src     = w_in;
      assign w_seg_cin = w_cin;
    end else begin : g_next
      assign w_src     = r_stg[k-1];
      assign w_seg_cin = r_stg[k-1].cout;
    end

    lin_seg_add #(.SEG(SEG)) u_seg (
      .a     (w_src.a[k*SEG +: SEG]),
      .b     (w_src.b[k*SEG +: SEG]),
      .cin   (w_seg_cin),
      .sum   (w_seg_sum),
      .carry (w_seg_carry),
      .cout  (w_seg_cout)
    );

    always_comb begin
      w_res                     = w_src;
      w_res.sum[k*SEG +: SEG]   = w_seg_sum;
      w_res.carry[k*SEG +: SEG] = w_seg_carry;
      w_res.cout                = w_seg_cout;
    end

    assign w_nxt[k] = w_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < S; i++) r_stg[i] <= '0;
      r_carry_hold <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < S; i++) begin
        if (w_load[i]) r_stg[i] <= w_nxt[i];
      end
      if (w_load[S-1] && w_nxt[S-1].valid) r_carry_hold <= w_nxt[S-1].cout;
    end
  end

  assign out_valid = r_stg[S-1].valid;
  assign out_sum   = r_stg[S-1].sum;
  assign out_co    = r_stg[S-1].cout;
  assign out_carry = r_stg[S-1].carry;
  assign out_ovf   = r_stg[S-1].carry[N-1] ^ r_stg[S-1].cout;

  // Consumed operand bits and the sub flag ride along but have no further reader.
  always_comb begin
    w_unused = 1'b0;
    for (int unsigned i = 0; i < S; i++) w_unused = w_unused ^ (^r_stg[i]);
  end

endmodule

// File: doc/lin_adder_pipe.md
Name: lin_adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational linearised adder.
- Splits an N-bit add/subtract into S equal segments. Each segment is resolved in its own register stage using the linear form s = a ^ b ^ c, with a per-segment generate/propagate carry.
- Adds a valid/ready handshake with backpressure, subtract mode, and multi-word chaining (carry-in taken from the previous result).
- Sits between operand sources and the datapath result bus.

Parameters:
- N, 32, operand width in bits. N % S must be 0; elaboration error otherwise.
- S, 4, pipeline stages, which is also the segment count. 1 <= S <= N.
- SEG, N/S, segment width. Derived; not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_sub  in  1  1: compute A - B (B inverted, carry-in 1).
- in_chain  in  1  1: carry-in = carry_hold (multi-word continuation).
- out_valid  out  1  result present in stage S.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_sum  out  N  sum/difference.
- out_co  out  1  carry out of bit N-1. For subtract, 1 means no borrow.
- out_ovf  out  1  signed overflow: carry into bit N-1 XOR out_co.
- out_carry  out  N  carry into each bit; bit 0 equals the effective carry-in.

Behaviour:
- Reset:
  - All stage valid bits are 0; out_valid = 0; carry_hold = 0.
  - out_sum, out_co, out_ovf and out_carry are all 0.
  - in_ready = 1 on the cycle after rst deasserts.
  - Reset mid-operation flushes every in-flight beat without emitting it.
- Pipeline:
  - Stage k (1..S) registers the sum bits of segment k-1 and the carry out of segment k-1.
  - Stage k also carries forward the not-yet-used operand bits (b already inverted if sub) and the sub flag.
  - Stage 1 computes segment 0 from the effective carry-in: 0 for add, 1 for sub, carry_hold if chain. If both sub and chain are set, carry_hold is used.
- Latency:
  - Exactly S cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is 1 beat per cycle.
- Flow control:
  - Stage k loads when stage k is empty, or when stage k+1 will load (stage S: out_ready).
  - Bubbles collapse.
  - in_ready = stage 1 empty, or stage 1 advancing.
  - in_ready is combinational from out_ready and the stage valid bits only; it must not depend on in_valid.
- Output hold: while out_valid & !out_ready, all out_* signals are stable.
- Chaining:
  - carry_hold is updated with out_co at the moment a beat loads into stage S.
  - A beat with in_chain=1 is accepted only when stages 1..S-1 are all empty. Otherwise in_ready = 0 for that beat.
  - A non-chained beat behind a held chained beat is not reordered.
  - With S=1, a chained beat is accepted only when stage 1 is empty or advancing, and it uses out_co of the beat currently leaving.
- Simultaneous events:
  - Accept and emit in the same cycle is legal at full throughput.
  - rst has priority over every handshake.
- Arithmetic:
  - Results are modulo 2^N.
  - out_carry[i] = carry into bit i, matching the r-vector convention of the linear adder.
  - For i >= 1 this is the carry out of bit i-1.
- Boundary case: when all stages are full and out_ready = 0, in_ready = 0 and nothing is lost.

Decomposition:
- Package lin_adder_pkg:
  - function for segment count/width checks;
  - constant CIN_ADD = 0 and CIN_SUB = 1;
  - struct typedef for stage payload: remaining a, b, sum bits, carry vector, cout, valid.
- Sub-module lin_seg_add (SEG-bit combinational slice):
  - inputs a, b, cin;
  - outputs sum = a ^ b ^ c, per-bit carry vector, cout;
  - uses generate/propagate internally;
  - instantiated S times, one per stage.

Test Plan (N=8, S=2 unless noted):
- Add 0x7F + 0x01, no backpressure -> after 2 cycles out_sum=0x80, out_co=0, out_ovf=1, out_carry=0xFE.
- Sub 0x05 - 0x07 -> out_sum=0xFE, out_co=0 (borrow), out_ovf=0. Then 0x80 - 0x01 -> out_sum=0x7F, out_co=1, out_ovf=1.
- Chain 16-bit 0x01FF + 0x0001:
  - low beat 0xFF + 0x01 gives out_sum=0x00, out_co=1;
  - high beat 0x01 + 0x00 with in_chain=1 gives 0x02;
  - the high beat's in_ready stays 0 until the low beat reaches stage 2.
- Stream 10 back-to-back beats with out_ready toggling 1,0,0,1 -> all 10 results emitted in order, none dropped or duplicated, outputs stable while stalled, in_ready low only when both stages are full.
- rst asserted for 1 cycle with 2 beats in flight -> next cycle out_valid=0, carry_hold=0, no stale result; a following chained beat 0x01 + 0x01 gives 0x02.
- N=32, S=4, 0xFFFFFFFF + 0x00000001 -> latency 4, out_sum=0, out_co=1, out_carry=0xFFFFFFFE.
